// File: rtl/cram_loader.sv
// Configuration-RAM loader: accepts host words, serialises them MSB first
// onto the CRAM chain and accumulates a CRC-16-CCITT of every shifted bit.
module cram_loader #(
   parameter int unsigned CHAIN_LEN  = 20,
   parameter int unsigned WORD_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  word_valid,
   input  logic [WORD_WIDTH-1:0] word_data,
   output logic                  word_ready,
   output logic                  cfg_data,
   output logic                  cfg_shift,
   output logic                  cfg_en,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [15:0]           crc
);

   localparam int unsigned NUM_WORDS = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
   // Bits taken from the final word; the unused LSBs are dropped.
   localparam int unsigned LAST_BITS = ((CHAIN_LEN % WORD_WIDTH) == 0) ? WORD_WIDTH
                                                                      : (CHAIN_LEN % WORD_WIDTH);
   localparam int unsigned BCW = $clog2(CHAIN_LEN + 1);
   localparam int unsigned WCW = $clog2(NUM_WORDS + 1);
   localparam int unsigned SCW = $clog2(WORD_WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

   state_e                state_q, state_d;
   logic [WORD_WIDTH-1:0] sr_q, sr_d;
   logic [SCW-1:0]        sr_cnt_q, sr_cnt_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0]        word_cnt_q, word_cnt_d;
   logic                  cfg_data_q, cfg_data_d;
   logic                  cfg_shift_q, cfg_shift_d;
   logic                  cfg_en_q, cfg_en_d;
   logic                  aborted_q, aborted_d;
   logic [15:0]           crc_q, crc_d;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   // Next-state: session control, word intake, bit emission and CRC update.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      sr_cnt_d    = sr_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      word_cnt_d  = word_cnt_q;
      cfg_data_d  = cfg_data_q;
      cfg_shift_d = 1'b0;
      cfg_en_d    = cfg_en_q;
      aborted_d   = 1'b0;
      crc_d       = crc_q;
      word_ready  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StLoad;
               sr_d       = '0;
               sr_cnt_d   = '0;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               crc_d      = 16'hFFFF;
            end
         end
         StLoad: begin
            // Ready when empty or when the last held bit leaves this cycle.
            word_ready = (word_cnt_q < WCW'(NUM_WORDS)) && (sr_cnt_q <= SCW'(1));
            if (abort) begin
               state_d   = StIdle;
               cfg_en_d  = 1'b0;
               aborted_d = 1'b1;
            end else if (bit_cnt_q == BCW'(CHAIN_LEN)) begin
               // This cycle presents the final shift; finish next.
               state_d  = StDone;
               cfg_en_d = 1'b0;
            end else begin
               cfg_en_d = 1'b1;
               if (sr_cnt_q != '0) begin
                  cfg_data_d  = sr_q[WORD_WIDTH-1];
                  cfg_shift_d = 1'b1;
                  sr_d        = sr_q << 1;
                  sr_cnt_d    = sr_cnt_q - SCW'(1);
                  bit_cnt_d   = bit_cnt_q + BCW'(1);
                  crc_d       = crc_step(crc_q, sr_q[WORD_WIDTH-1]);
               end
               if (word_ready && word_valid) begin
                  sr_d       = word_data;
                  sr_cnt_d   = (word_cnt_q == WCW'(NUM_WORDS - 1)) ? SCW'(LAST_BITS)
                                                                   : SCW'(WORD_WIDTH);
                  word_cnt_d = word_cnt_q + WCW'(1);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         sr_q        <= '0;
         sr_cnt_q    <= '0;
         bit_cnt_q   <= '0;
         word_cnt_q  <= '0;
         cfg_data_q  <= 1'b0;
         cfg_shift_q <= 1'b0;
         cfg_en_q    <= 1'b0;
         aborted_q   <= 1'b0;
         crc_q       <= 16'hFFFF;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         sr_cnt_q    <= sr_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         word_cnt_q  <= word_cnt_d;
         cfg_data_q  <= cfg_data_d;
         cfg_shift_q <= cfg_shift_d;
         cfg_en_q    <= cfg_en_d;
         aborted_q   <= aborted_d;
         crc_q       <= crc_d;
      end
   end

   assign cfg_data  = cfg_data_q;
   assign cfg_shift = cfg_shift_q;
   assign cfg_en    = cfg_en_q;
   assign busy      = (state_q == StLoad);
   assign done      = (state_q == StDone);
   assign aborted   = aborted_q;
   assign crc       = crc_q;

endmodule

// File: doc/cram_loader.md
CRAM_LOADER -- requirements
Module: cram_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 20, total configuration-chain length in bits (>= 1).
REQ-002 SHALL have parameter WORD_WIDTH, default 8, host word width in bits (>= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a load session; sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  terminate the active session; sampled in LOAD only.
REQ-007 SHALL have port word_valid  input  1  host word available.
REQ-008 SHALL have port word_data  input  WORD_WIDTH  host configuration word, MSB shifted first.
REQ-009 SHALL have port word_ready  output  1  loader accepts word_data this cycle.
REQ-010 SHALL have port cfg_data  output  1  serial bit to the chain head (fabric config_data_in).
REQ-011 SHALL have port cfg_shift  output  1  one-cycle shift strobe to the CRAM chain (fabric en).
REQ-012 SHALL have port cfg_en  output  1  configuration-mode enable (fabric config_en).
REQ-013 SHALL have port busy  output  1  high in LOAD.
REQ-014 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-015 SHALL have port aborted  output  1  one-cycle pulse on abort.
REQ-016 SHALL have port crc  output  16  CRC of all bits shifted in the current/last session.

Function
REQ-017 SHALL implement states IDLE, LOAD, DONE.
REQ-018 IDLE -> LOAD on start=1; clears bit counter, word counter, shift register; crc loads 0xFFFF.
REQ-019 Word transfer SHALL occur on a cycle with word_valid=1 and word_ready=1 only.
REQ-020 word_ready SHALL be combinational: high in LOAD when words accepted < ceil(CHAIN_LEN/WORD_WIDTH) and the shift register holds 0 bits or is emitting its last bit this cycle; low otherwise.
REQ-021 An accepted word SHALL load the shift register; bits emitted one per cycle, MSB first, with no gap cycles while word_valid stays high (back-to-back).
REQ-022 Final word, when CHAIN_LEN mod WORD_WIDTH = R != 0: only its R MSBs SHALL be shifted; remaining LSBs discarded.
REQ-023 cfg_data and cfg_shift SHALL be registered; cfg_shift=1 exactly on cycles presenting a valid bit on cfg_data; cfg_data holds its last value when cfg_shift=0.
REQ-024 Exactly CHAIN_LEN cfg_shift pulses SHALL occur per successful session; bit counter width $clog2(CHAIN_LEN+1).
REQ-025 Host stall (no word available when the shift register empties) SHALL deassert cfg_shift without losing or duplicating bits.
REQ-026 cfg_en SHALL be high from the cycle after LOAD entry through the cycle carrying the final cfg_shift, low otherwise.
REQ-027 LOAD -> DONE on the cycle after the CHAIN_LEN-th shift; DONE asserts done=1 for one cycle, then -> IDLE.
REQ-028 crc SHALL be CRC-16-CCITT (poly 0x1021, init 0xFFFF, non-reflected, no final XOR), updated once per shifted bit, held stable from DONE until the next start.
REQ-029 abort=1 in LOAD SHALL -> IDLE next cycle: cfg_shift, cfg_en, word_ready low; aborted=1 one cycle; done not asserted; crc holds partial value.
REQ-030 abort and the final shift on the same cycle: abort SHALL win (no done).
REQ-031 start outside IDLE and abort outside LOAD SHALL be ignored; start and abort together in IDLE: start wins.
REQ-032 busy SHALL equal (state == LOAD).

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE; word_ready, cfg_data, cfg_shift, cfg_en, busy, done, aborted = 0; crc = 0xFFFF; counters and shift register = 0.
REQ-034 rst asserted mid-LOAD SHALL discard the session with no done or aborted pulse; the next session starts only on a new start.

Verification
REQ-035 CHAIN_LEN=20, W=8, start, words 0xA5,0x3C,0xF0 valid continuously -> cfg_data stream 10100101 00111100 1111, 20 consecutive cfg_shift cycles, done 1 cycle after the 20th shift, 3 word handshakes.
REQ-036 Same load with word_valid low for 5 cycles between words 1 and 2 -> cfg_shift gap of at least 5 cycles, identical 20-bit stream, total shifts = 20.
REQ-037 CHAIN_LEN=72, W=8, ASCII "123456789" -> crc = 0x29B1 at done.
REQ-038 Abort after 10 shifts -> aborted pulse, no done, cfg_en low next cycle, word_ready low; a fresh start then completes a full 20-bit load normally.
REQ-039 rst pulse after 7 shifts -> all outputs 0, crc 0xFFFF immediately; start with no words supplied -> word_ready=1, cfg_shift stays 0.
